vec_normalize: RTL and testbench

- Sequential initiator for the Goldschmidt reciprocal-square-root pipeline. Takes a signed fixed-point 3-vector, computes S = x²+y²+z², and derives a power-of-two seed y0 from the leading-one position of S.
- Drives the rsqrt unit's start/in/est side and waits for its valid. It then scales each component by the returned rsqrt to emit a unit vector.
- Sits in the ray-generation path between direction setup and the traversal front end.

---
 rtl/vec_normalize.sv | 178 +++++++++++++++++
 tb/tb_vec_normalize.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_normalize.sv
// vec_normalize: forms S = x^2+y^2+z^2, seeds and drives an external rsqrt unit, then scales the vector to unit length.
// Optional out_len port (latched sqrt(S)) is enabled by defining VEC_NORMALIZE_LENGTH_EN.
`default_nettype none

module vec_normalize #(
  parameter int IW = 8,
  parameter int QW = 8,
  localparam int W = IW + QW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_z,
  output logic         out_zero,
  output logic         out_sat,
  output logic         rs_start,
  output logic [W-1:0] rs_s,
  output logic [W-1:0] rs_est,
  input  logic         rs_valid,
  input  logic [W-1:0] rs_rsqrt,
`ifdef VEC_NORMALIZE_LENGTH_EN
  output logic [W-1:0] out_len,
`endif
  input  logic [W-1:0] rs_sqrt
);

  localparam int PW = $clog2(W);
  localparam logic signed [2*W+1:0] c_s_max = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] c_p_max = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] c_n_min = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOT   = 3'd1,
    ST_EST   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SCALE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t r_state, w_next;

  logic signed [W-1:0]     r_x, r_y, r_z, r_rsqrt;
  logic        [W-1:0]     r_s;
  logic signed [2*W-1:0]   w_sqx, w_sqy, w_sqz;
  logic signed [2*W+1:0]   w_sum, w_dot;
  logic                    w_dot_ovf;
  logic        [W-1:0]     w_s_next;
  logic        [PW-1:0]    w_msb;
  int                      w_e, w_k, w_sh;
  logic        [W-1:0]     w_est;
  logic signed [2*W-1:0]   w_px, w_py, w_pz;

  function automatic logic [W-1:0] f_sat(input logic signed [2*W-1:0] v);
    if (v > c_p_max)      return {1'b0, {(W-1){1'b1}}};
    else if (v < c_n_min) return {1'b1, {(W-1){1'b0}}};
    else                  return v[W-1:0];
  endfunction

  assign w_sqx     = (2*W)'(r_x) * (2*W)'(r_x);
  assign w_sqy     = (2*W)'(r_y) * (2*W)'(r_y);
  assign w_sqz     = (2*W)'(r_z) * (2*W)'(r_z);
  assign w_sum     = (2*W+2)'(w_sqx) + (2*W+2)'(w_sqy) + (2*W+2)'(w_sqz);
  assign w_dot     = w_sum >>> QW;
  assign w_dot_ovf = (w_dot > c_s_max);
  assign w_s_next  = w_dot_ovf ? {1'b0, {(W-1){1'b1}}} : w_dot[W-1:0];

  // Seed exponent: shift = clamp(QW - ceil((msb(S) - QW) / 2), 0, W-2)
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < W; i++) begin
      if (r_s[i]) w_msb = PW'(i);
    end
    w_e  = int'(w_msb) - QW;
    w_k  = (w_e + 1) >>> 1;
    w_sh = QW - w_k;
    if (w_sh < 0)          w_sh = 0;
    else if (w_sh > W - 2) w_sh = W - 2;
    w_est = {{(W-1){1'b0}}, 1'b1} << w_sh;
  end

  assign w_px = (2*W)'(r_x) * (2*W)'(r_rsqrt);
  assign w_py = (2*W)'(r_y) * (2*W)'(r_rsqrt);
  assign w_pz = (2*W)'(r_z) * (2*W)'(r_rsqrt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next = ST_DOT;
      ST_DOT:   w_next = ST_EST;
      ST_EST:   w_next = (r_s == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (rs_valid) w_next = ST_SCALE;
      ST_SCALE: w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign rs_start  = (r_state == ST_ISSUE);
  assign out_valid = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_s      <= '0;
      r_rsqrt  <= '0;
      rs_s     <= '0;
      rs_est   <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
      out_zero <= 1'b0;
      out_sat  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_x      <= in_x;
          r_y      <= in_y;
          r_z      <= in_z;
          out_zero <= 1'b0;
          out_sat  <= 1'b0;
        end
        ST_DOT: begin
          r_s <= w_s_next;
          if (w_dot_ovf) out_sat <= 1'b1;
        end
        ST_EST: if (r_s == '0) begin
          out_x    <= '0;
          out_y    <= '0;
          out_z    <= '0;
          out_zero <= 1'b1;
        end else begin
          rs_s   <= r_s;
          rs_est <= w_est;
        end
        ST_WAIT: if (rs_valid) r_rsqrt <= rs_rsqrt;
        ST_SCALE: begin
          out_x <= f_sat(w_px >>> QW);
          out_y <= f_sat(w_py >>> QW);
          out_z <= f_sat(w_pz >>> QW);
        end
        default: ;
      endcase
    end
  end

`ifdef VEC_NORMALIZE_LENGTH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 out_len <= '0;
    else if (r_state == ST_EST && r_s == '0)   out_len <= '0;
    else if (r_state == ST_WAIT && rs_valid)   out_len <= rs_sqrt;
  end
`else
  logic w_unused_sqrt;
  assign w_unused_sqrt = ^rs_sqrt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_normalize.sv
// tb_vec_normalize: randomized and directed bench for vec_normalize with an rsqrt stub and a behavioural model.
`default_nettype none

module tb_vec_normalize;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b0, rs_valid = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic [W-1:0] rs_rsqrt = '0, rs_sqrt = '0;
  logic         in_ready, out_valid, out_zero, out_sat, rs_start;
  logic [W-1:0] out_x, out_y, out_z, rs_s, rs_est;
`ifdef VEC_NORMALIZE_LENGTH_EN
  logic [W-1:0] out_len;
`endif

  vec_normalize dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_zero(out_zero), .out_sat(out_sat),
    .rs_start(rs_start), .rs_s(rs_s), .rs_est(rs_est),
    .rs_valid(rs_valid), .rs_rsqrt(rs_rsqrt),
`ifdef VEC_NORMALIZE_LENGTH_EN
    .out_len(out_len),
`endif
    .rs_sqrt(rs_sqrt)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model_se(input logic signed [15:0] x, y, z,
                                   output longint s, output bit sat, output longint est);
    longint sum, p, e, k, sh;
    sum = longint'(x) * longint'(x) + longint'(y) * longint'(y) + longint'(z) * longint'(z);
    s   = sum / 256;
    sat = (s > 32767);
    if (sat) s = 32767;
    p = 0;
    for (int i = 0; i < 16; i++) if (s >= (64'sd1 << i)) p = i;
    e  = p - 8;
    k  = (e > 0) ? (e + 1) / 2 : -((-e) / 2);
    sh = 8 - k;
    if (sh < 0) sh = 0;
    if (sh > 14) sh = 14;
    est = (s == 0) ? 0 : (64'sd1 << sh);
  endfunction

  function automatic logic [15:0] f_scale(input longint c, input longint r);
    longint q;
    q = (c * r) >>> 8;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // ---------------- rsqrt stub ----------------
  int          stub_L = 5;
  logic [15:0] stub_rsqrt = '0, stub_sqrt = '0;
  int          stub_cnt = 0;
  int          spur_cnt = 0, spur_done = 0;

  always @(negedge clk) begin
    rs_valid = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        rs_valid = 1'b1;
        rs_rsqrt = stub_rsqrt;
        rs_sqrt  = stub_sqrt;
      end
    end
    if (spur_cnt != spur_done) begin
      rs_valid  = 1'b1;
      rs_rsqrt  = 16'h1234;
      rs_sqrt   = 16'h4321;
      spur_done = spur_cnt;
    end
    if (rs_start && !reset) stub_cnt = stub_L;
  end

  // ---------------- compare process ----------------
  bit                 busy = 0, prev_ov = 0, exp_sat;
  int                 acc, exp_L, starts;
  logic signed [15:0] cx, cy, cz;
  longint             exp_s, exp_est;
  logic [15:0]        exp_r, exp_len, ex, ey, ez;
  logic [15:0]        obs_s, obs_est, obs_x, obs_y, obs_z;
  int                 obs_lat, obs_starts;
  bit                 obs_zero, obs_sat;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_rs_start", rs_start, 0);
      chk("rst_out_valid", out_valid, 0);
      busy    = 0;
      prev_ov = 0;
    end else begin
      chk("in_ready", in_ready, !busy);
      if (!busy) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_rs_start", rs_start, 0);
      end else begin
        if (rs_start) begin
          starts++;
          obs_s   = rs_s;
          obs_est = rs_est;
          chk("rs_start_cycle", cyc + 1 - acc, 3);
          chk("rs_s", rs_s, exp_s);
          chk("rs_est", rs_est, exp_est);
        end
        if (out_valid) begin
          if (!prev_ov) begin
            obs_lat    = cyc + 1 - acc;
            obs_starts = starts;
            chk("latency", obs_lat, (exp_s == 0) ? 3 : 5 + exp_L);
            chk("start_count", starts, (exp_s == 0) ? 0 : 1);
            ex = (exp_s == 0) ? 16'h0 : f_scale(cx, longint'($signed(exp_r)));
            ey = (exp_s == 0) ? 16'h0 : f_scale(cy, longint'($signed(exp_r)));
            ez = (exp_s == 0) ? 16'h0 : f_scale(cz, longint'($signed(exp_r)));
          end
          chk("out_x", out_x, ex);
          chk("out_y", out_y, ey);
          chk("out_z", out_z, ez);
          chk("out_zero", out_zero, exp_s == 0);
          chk("out_sat", out_sat, exp_sat);
`ifdef VEC_NORMALIZE_LENGTH_EN
          chk("out_len", out_len, (exp_s == 0) ? 0 : exp_len);
`endif
          obs_x = out_x; obs_y = out_y; obs_z = out_z;
          obs_zero = out_zero; obs_sat = out_sat;
          if (out_ready) busy = 0;
        end
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        busy   = 1;
        acc    = cyc + 1;
        starts = 0;
        cx = in_x; cy = in_y; cz = in_z;
        model_se(cx, cy, cz, exp_s, exp_sat, exp_est);
        exp_r   = stub_rsqrt;
        exp_len = stub_sqrt;
        exp_L   = stub_L;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_vec(input logic [15:0] x, y, z, r, sq, input int L);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    stub_rsqrt = r; stub_sqrt = sq; stub_L = L;
    in_x = x; in_y = y; in_z = z;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    if (!out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [15:0] x, y, z, r, sq, input int L, input int hold, input bit early);
    start_vec(x, y, z, r, sq, L);
    if (early) out_ready = 1'b1;
    wait_ov();
    repeat (early ? 0 : hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] rnd_comp(input int mode);
    int v;
    case (mode)
      0: v = $urandom_range(0, 1536);
      1: v = $urandom_range(0, 32767);
      2: v = $urandom_range(0, 15);
      default: v = $urandom_range(0, 1) ? 0 : $urandom_range(0, 4096);
    endcase
    if ($urandom_range(0, 1)) v = -v;
    return 16'(v);
  endfunction

  initial begin
    longint s, est;
    bit     sat;

    // model pins
    model_se(16'sh0300, 16'sh0400, 16'sh0000, s, sat, est);
    chk("pin_model_s", s, 'h1900);
    chk("pin_model_est", est, 'h40);
    chk("pin_model_scale", f_scale(768, 46), 138);
    model_se(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, s, sat, est);
    chk("pin_model_sat", sat, 1);

    step();
    chk("rst_out_x", out_x, 0);
    chk("rst_rs_s", rs_s, 0);
    chk("rst_rs_est", rs_est, 0);
    chk("rst_flags", {out_zero, out_sat}, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // nominal
    send(16'h0300, 16'h0400, 16'h0000, 16'h002E, 16'h047E, 5, 0, 0);
    chk("nom_rs_s", obs_s, 'h1900);
    chk("nom_rs_est", obs_est, 'h0040);
    chk("nom_out_x", obs_x, 'h008A);
    chk("nom_out_y", obs_y, 'h00B8);
    chk("nom_out_z", obs_z, 'h0000);
    chk("nom_latency", obs_lat, 10);
    chk("nom_starts", obs_starts, 1);
`ifdef VEC_NORMALIZE_LENGTH_EN
    chk("nom_out_len", out_len, 'h047E);
`endif

    // exact seed
    send(16'h0200, 16'h0000, 16'h0000, 16'h0080, 16'h0200, 5, 1, 0);
    chk("seed_rs_s", obs_s, 'h0400);
    chk("seed_rs_est", obs_est, 'h0080);
    chk("seed_out_x", obs_x, 'h0100);

    // zero vector
    send(16'h0000, 16'h0000, 16'h0000, 16'h0055, 16'h0055, 5, 0, 0);
    chk("zero_flag", obs_zero, 1);
    chk("zero_latency", obs_lat, 3);
    chk("zero_starts", obs_starts, 0);

    // saturation
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h002D, 16'h00DD, 3, 0, 1);
    chk("sat_rs_s", obs_s, 'h7FFF);
    chk("sat_flag", obs_sat, 1);
    chk("sat_out_x", obs_x, 'h167F);

    // spurious rs_valid in IDLE
    spur_cnt++;
    repeat (3) step();
    chk("spur_out_valid", out_valid, 0);
    chk("spur_in_ready", in_ready, 1);

    // backpressure with a second vector waiting on in_valid
    start_vec(16'h0100, 16'hFF00, 16'h0080, 16'h00A0, 16'h0180, 4);
    wait_ov();
    in_x = 16'h0040; in_y = 16'h0040; in_z = 16'hFFC0;
    stub_rsqrt = 16'h0180; stub_sqrt = 16'h0070; stub_L = 2;
    in_valid = 1'b1;
    repeat (4) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    wait_ov();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset while waiting on the rsqrt unit
    start_vec(16'h0100, 16'h0100, 16'h0100, 16'h0094, 16'h01BB, 5);
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("rstw_rs_start", rs_start, 0);
    chk("rstw_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    chk("rstw_in_ready", in_ready, 1);
    repeat (6) begin
      step();
      chk("rstw_no_output", out_valid, 0);
    end

    // randomized
    for (int i = 0; i < 40; i++) begin
      int          mode;
      logic [15:0] x, y, z, r;
      mode = $urandom_range(0, 3);
      x = rnd_comp(mode); y = rnd_comp(mode); z = rnd_comp(mode);
      if (i % 13 == 0) begin x = '0; y = '0; z = '0; end
      r = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(1, 512));
      send(x, y, z, r, 16'($urandom), $urandom_range(1, 8), $urandom_range(0, 3),
           $urandom_range(0, 3) == 0);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
